// File: rtl/decoder_scan_driver_pkg.sv
// Shared types and channel-priority helper for the v74x139 scan sequencer.
package decoder_scan_driver_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StBlank  = 2'd2
  } scan_state_e;

  // Bit 2 set marks "no channel found"; bits [1:0] are the channel index otherwise.
  localparam logic [2:0] CH_NONE = 3'b100;

  // Lowest set bit of mask at or above index from; CH_NONE if there is none.
  function automatic logic [2:0] next_channel(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] ch;
    ch = CH_NONE;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(from) && mask[i]) begin
        ch = 3'(i);
      end
    end
    return ch;
  endfunction

endpackage

// File: rtl/decoder_scan_driver_dwell_counter.sv
// Loadable saturating down-counter; used for both the dwell and the blank interval.
module decoder_scan_driver_dwell_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  // Load wins over decrement; the count sticks at zero instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/decoder_scan_driver.sv
// Scan sequencer driving G/A/B of a v74x139: dwell on each enabled channel, optional blank gap,
// one-shot or continuous frames, immediate stop.
module decoder_scan_driver
  import decoder_scan_driver_pkg::*;
#(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned BLANK_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [BLANK_W-1:0] blank,
  output logic               G,
  output logic               A,
  output logic               B,
  output logic               busy,
  output logic               frame_done
);

  scan_state_e state_q;
  logic [3:0]  mask_q;

  logic               dwell_zero;
  logic               blank_zero;
  logic [2:0]         cur_ch;
  logic [2:0]         nxt_ch;
  logic [2:0]         first_ch;
  logic [1:0]         tgt_ch;
  logic [DWELL_W-1:0] dwell_min;
  logic [DWELL_W-1:0] dwell_load_val;
  logic               period_end;
  logic               go_blank;
  logic               launch;
  logic               step;
  logic               frame_end;
  logic               wrap;
  logic               cnt_load;
  logic               dwell_en;
  logic               blank_en;

  always_comb begin
    cur_ch     = {1'b0, B, A};
    nxt_ch     = next_channel(mask_q, cur_ch + 3'd1);
    first_ch   = next_channel(mask, 3'd0);
    dwell_min  = (dwell == '0) ? DWELL_W'(1) : dwell;

    go_blank   = (state_q == StActive) && dwell_zero && !blank_zero;
    period_end = ((state_q == StActive) && dwell_zero && blank_zero) ||
                 ((state_q == StBlank) && blank_zero);
    launch     = (state_q == StIdle) && start && (first_ch != CH_NONE);
    step       = period_end && (nxt_ch != CH_NONE);
    frame_end  = period_end && (nxt_ch == CH_NONE);
    wrap       = frame_end && cont && (first_ch != CH_NONE);
    tgt_ch     = step ? nxt_ch[1:0] : first_ch[1:0];

    cnt_load   = !stop && (launch || step || wrap);
    // The frame_done cycle of a continuous scan already shows the first channel with G low,
    // so that channel gets one extra active cycle on top of its dwell.
    dwell_load_val = wrap ? dwell_min : dwell_min - DWELL_W'(1);
    dwell_en   = (state_q == StActive) && !dwell_zero;
    // Blank count is sampled on ACTIVE entry and already steps once on the way into BLANK.
    blank_en   = go_blank || ((state_q == StBlank) && !blank_zero);
  end

  decoder_scan_driver_dwell_counter #(
    .W (DWELL_W)
  ) u_dwell_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (dwell_load_val),
    .en_i       (dwell_en),
    .zero_o     (dwell_zero)
  );

  decoder_scan_driver_dwell_counter #(
    .W (BLANK_W)
  ) u_blank_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (blank),
    .en_i       (blank_en),
    .zero_o     (blank_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      G          <= 1'b1;
      A          <= 1'b0;
      B          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (stop) begin
        state_q <= StIdle;
        G       <= 1'b1;
        busy    <= 1'b0;
      end else if (launch || step || wrap) begin
        state_q <= StActive;
        G       <= 1'b0;
        busy    <= 1'b1;
        {B, A}  <= tgt_ch;
        if (launch || wrap) begin
          mask_q <= mask;
        end
        if (wrap) begin
          frame_done <= 1'b1;
        end
      end else if (go_blank) begin
        state_q <= StBlank;
        G       <= 1'b1;
      end else if (frame_end) begin
        state_q    <= StIdle;
        G          <= 1'b1;
        busy       <= 1'b0;
        frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Directed scoreboard bench for decoder_scan_driver with a v74x139 output model.
module tb_decoder_scan_driver;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        cont;
  logic [3:0]  mask;
  logic [15:0] dwell;
  logic [3:0]  blank;
  logic        G;
  logic        A;
  logic        B;
  logic        busy;
  logic        frame_done;

  typedef struct packed {
    logic       g;
    logic [1:0] ch;
    logic       busy;
    logic       fd;
  } exp_t;

  exp_t  exp_q[$];
  string phase;
  int    checks = 0;
  int    passes = 0;
  int    fails  = 0;

  decoder_scan_driver #(
    .DWELL_W (16),
    .BLANK_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
    .mask       (mask),
    .dwell      (dwell),
    .blank      (blank),
    .G          (G),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] v139(input logic g, input logic b, input logic a);
    logic [3:0] y;
    y = 4'b1111;
    if (!g) y[{b, a}] = 1'b0;
    return y;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic expect_n(input int n, input logic g, input logic [1:0] ch, input logic bz,
                          input logic fd);
    exp_t e;
    e = '{g: g, ch: ch, busy: bz, fd: fd};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Each queued entry is one cycle of DUT output; start/stop are one-edge pulses.
  task automatic drain();
    exp_t e;
    int   idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d] {G,B,A,busy,done}", phase, idx),
            {G, B, A, busy, frame_done}, e);
      check($sformatf("%s[%0d] Y", phase, idx),
            {1'b0, v139(G, B, A)}, {1'b0, v139(e.g, e.ch[1], e.ch[0])});
      idx++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
    mask = 4'b0000; dwell = 16'd0; blank = 4'd0;

    phase = "reset";
    expect_n(2, 1'b1, 2'd0, 1'b0, 1'b0);
    drain();
    reset = 1'b0;
    phase = "idle";
    expect_n(2, 1'b1, 2'd0, 1'b0, 1'b0);
    drain();

    phase = "full_scan";
    mask = 4'b1111; dwell = 16'd3; blank = 4'd0; cont = 1'b0; start = 1'b1;
    for (int c = 0; c < 4; c++) expect_n(3, 1'b0, 2'(c), 1'b1, 1'b0);
    expect_n(1, 1'b1, 2'd3, 1'b0, 1'b1);
    expect_n(1, 1'b1, 2'd3, 1'b0, 1'b0);
    drain();

    phase = "sparse_blank";
    mask = 4'b1010; dwell = 16'd2; blank = 4'd1; start = 1'b1;
    expect_n(2, 1'b0, 2'd1, 1'b1, 1'b0);
    expect_n(1, 1'b1, 2'd1, 1'b1, 1'b0);
    expect_n(2, 1'b0, 2'd3, 1'b1, 1'b0);
    expect_n(1, 1'b1, 2'd3, 1'b1, 1'b0);
    expect_n(1, 1'b1, 2'd3, 1'b0, 1'b1);
    expect_n(1, 1'b1, 2'd3, 1'b0, 1'b0);
    drain();

    phase = "start_mask0";
    mask = 4'b0000; start = 1'b1;
    expect_n(3, 1'b1, 2'd3, 1'b0, 1'b0);
    drain();

    phase = "start_busy";
    mask = 4'b0101; dwell = 16'd2; blank = 4'd0; start = 1'b1;
    expect_n(2, 1'b0, 2'd0, 1'b1, 1'b0);
    drain();
    mask = 4'b1111; start = 1'b1;
    expect_n(2, 1'b0, 2'd2, 1'b1, 1'b0);
    expect_n(1, 1'b1, 2'd2, 1'b0, 1'b1);
    expect_n(1, 1'b1, 2'd2, 1'b0, 1'b0);
    drain();

    phase = "cont_dwell0";
    cont = 1'b1; mask = 4'b0001; dwell = 16'd0; blank = 4'd0; start = 1'b1;
    repeat (3) begin
      expect_n(1, 1'b0, 2'd0, 1'b1, 1'b0);
      expect_n(1, 1'b0, 2'd0, 1'b1, 1'b1);
    end
    drain();
    stop = 1'b1;
    expect_n(2, 1'b1, 2'd0, 1'b0, 1'b0);
    drain();

    phase = "stop_at_end";
    start = 1'b1;
    expect_n(1, 1'b0, 2'd0, 1'b1, 1'b0);
    drain();
    stop = 1'b1;
    expect_n(2, 1'b1, 2'd0, 1'b0, 1'b0);
    drain();

    phase = "cont_blank";
    mask = 4'b0011; dwell = 16'd1; blank = 4'd2; start = 1'b1;
    expect_n(1, 1'b0, 2'd0, 1'b1, 1'b0);
    drain();
    mask = 4'b0100;
    expect_n(2, 1'b1, 2'd0, 1'b1, 1'b0);
    expect_n(1, 1'b0, 2'd1, 1'b1, 1'b0);
    expect_n(2, 1'b1, 2'd1, 1'b1, 1'b0);
    expect_n(1, 1'b0, 2'd2, 1'b1, 1'b1);
    expect_n(1, 1'b0, 2'd2, 1'b1, 1'b0);
    expect_n(1, 1'b1, 2'd2, 1'b1, 1'b0);
    drain();
    stop = 1'b1; cont = 1'b0;
    expect_n(2, 1'b1, 2'd2, 1'b0, 1'b0);
    drain();

    phase = "reset_mid";
    mask = 4'b1100; dwell = 16'd4; blank = 4'd0; start = 1'b1;
    expect_n(2, 1'b0, 2'd2, 1'b1, 1'b0);
    drain();
    reset = 1'b1;
    expect_n(1, 1'b1, 2'd0, 1'b0, 1'b0);
    drain();
    reset = 1'b0;
    expect_n(1, 1'b1, 2'd0, 1'b0, 1'b0);
    drain();

    phase = "restart";
    mask = 4'b1100; dwell = 16'd1; start = 1'b1;
    expect_n(1, 1'b0, 2'd2, 1'b1, 1'b0);
    expect_n(1, 1'b0, 2'd3, 1'b1, 1'b0);
    expect_n(1, 1'b1, 2'd3, 1'b0, 1'b1);
    expect_n(1, 1'b1, 2'd3, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
